// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU control unit.
// The CPU_CTRL_STEP_EN macro adds the single-step STEP_WAIT state.
package cpu_pkg;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JCC = 2'b11;

    localparam int MEM_LAT_MAX = 4;

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_OPFETCH   = 4'd3,
        ST_EXEC      = 4'd4,
        ST_STORE     = 4'd5,
`ifdef CPU_CTRL_STEP_EN
        ST_JUMP      = 4'd6,
        ST_STEP_WAIT = 4'd7
`else
        ST_JUMP      = 4'd6
`endif
    } state_t;

    // Value loaded into the wait counter so that a memory state lasts 'lat' cycles.
    function automatic logic [1:0] lat_load(input int lat);
        return 2'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable 2-bit down-counter timing the memory-access states of cpu_ctrl_fsm.
// done is high while the count is zero; the count only moves when ce=1.
module mem_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic       done
);

    logic [1:0] cnt_r;

    // Count register: load has priority, otherwise decrement and stick at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 2'd0;
        end else if (ce) begin
            if (load) begin
                cnt_r <= load_val;
            end else if (cnt_r != 2'd0) begin
                cnt_r <= cnt_r - 2'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == 2'd0);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute sequencer for the 2-bit-opcode accumulator CPU.
// Defining CPU_CTRL_STEP_EN adds the step input and the STEP_WAIT state.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
`ifdef CPU_CTRL_STEP_EN
    input  logic       step,
`endif
    input  logic [1:0] ins_op,
    input  logic       carry,
    output logic       clear_PC,
    output logic       load_PC,
    output logic       enable_PC,
    output logic       load_RI,
    output logic       sel_adr,
    output logic       load_ACC,
    output logic       sel_ual,
    output logic       load_carry,
    output logic       clear_carry,
    output logic       mem_ce,
    output logic       mem_we,
    output logic       instr_done,
    output logic [3:0] state_o
);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("cpu_ctrl_fsm: MEM_LAT must be in 1..%0d", MEM_LAT_MAX);
    end

    localparam logic [1:0] LAT_LOAD = lat_load(MEM_LAT);

    // Where a finished instruction (and INIT) goes next; FETCH entry reloads the counter.
`ifdef CPU_CTRL_STEP_EN
    localparam state_t TERM_ST   = ST_STEP_WAIT;
    localparam logic   TERM_LOAD = 1'b0;
`else
    localparam state_t TERM_ST   = ST_FETCH;
    localparam logic   TERM_LOAD = 1'b1;
`endif

    state_t     state_r;
    state_t     next_s;
    logic [1:0] op_r;
    logic       cnt_load_s;
    logic       cnt_done_s;
    logic       act_s;

    logic clear_pc_s, load_pc_s, enable_pc_s, load_ri_s, sel_adr_s, load_acc_s;
    logic sel_ual_s, load_carry_s, clear_carry_s, mem_ce_s, mem_we_s, done_s;

    mem_wait_cnt u_wait (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .load     (cnt_load_s),
        .load_val (LAT_LOAD),
        .done     (cnt_done_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= next_s;
        end
    end

    // Opcode latch; only bit 0 and the ADD decode are used after DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= OP_NOR;
        end else if (ce && state_r == ST_DECODE) begin
            op_r <= ins_op;
        end else begin
            op_r <= op_r;
        end
    end

    // Next-state logic; everything holds while ce is low.
    always_comb begin
        next_s     = state_r;
        cnt_load_s = 1'b0;
        if (ce) begin
            case (state_r)
                ST_INIT: begin
                    next_s     = TERM_ST;
                    cnt_load_s = TERM_LOAD;
                end
                ST_FETCH: begin
                    if (cnt_done_s) begin
                        next_s = ST_DECODE;
                    end else begin
                        next_s = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    case (ins_op)
                        OP_NOR, OP_ADD: begin
                            next_s     = ST_OPFETCH;
                            cnt_load_s = 1'b1;
                        end
                        OP_STA:  next_s = ST_STORE;
                        OP_JCC:  next_s = ST_JUMP;
                        default: next_s = ST_INIT;
                    endcase
                end
                ST_OPFETCH: begin
                    if (cnt_done_s) begin
                        next_s = ST_EXEC;
                    end else begin
                        next_s = ST_OPFETCH;
                    end
                end
                ST_EXEC, ST_STORE, ST_JUMP: begin
                    next_s     = TERM_ST;
                    cnt_load_s = TERM_LOAD;
                end
`ifdef CPU_CTRL_STEP_EN
                ST_STEP_WAIT: begin
                    if (step) begin
                        next_s     = ST_FETCH;
                        cnt_load_s = 1'b1;
                    end else begin
                        next_s = ST_STEP_WAIT;
                    end
                end
`endif
                default: next_s = ST_INIT;
            endcase
        end else begin
            next_s = state_r;
        end
    end

    // Moore strobe decode from state, latched opcode and live carry.
    always_comb begin
        clear_pc_s    = 1'b0;
        load_pc_s     = 1'b0;
        enable_pc_s   = 1'b0;
        load_ri_s     = 1'b0;
        sel_adr_s     = 1'b0;
        load_acc_s    = 1'b0;
        sel_ual_s     = 1'b0;
        load_carry_s  = 1'b0;
        clear_carry_s = 1'b0;
        mem_ce_s      = 1'b0;
        mem_we_s      = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            ST_INIT: begin
                clear_pc_s  = 1'b1;
                enable_pc_s = 1'b1;
            end
            ST_FETCH: mem_ce_s = 1'b1;
            ST_DECODE: begin
                load_ri_s   = 1'b1;
                enable_pc_s = 1'b1;
            end
            ST_OPFETCH: begin
                mem_ce_s  = 1'b1;
                sel_adr_s = 1'b1;
            end
            ST_EXEC: begin
                load_acc_s   = 1'b1;
                sel_ual_s    = op_r[0];
                load_carry_s = (op_r == OP_ADD);
                done_s       = 1'b1;
            end
            ST_STORE: begin
                mem_ce_s  = 1'b1;
                mem_we_s  = 1'b1;
                sel_adr_s = 1'b1;
                done_s    = 1'b1;
            end
            ST_JUMP: begin
                load_pc_s     = ~carry;
                clear_carry_s = carry;
                done_s        = 1'b1;
            end
            default: done_s = 1'b0;
        endcase
    end

    // rst is in the gate so nothing, not even the INIT strobes, leaks during reset.
    assign act_s = ce & ~rst;

    assign clear_PC    = clear_pc_s    & act_s;
    assign load_PC     = load_pc_s     & act_s;
    assign enable_PC   = enable_pc_s   & act_s;
    assign load_RI     = load_ri_s     & act_s;
    assign sel_adr     = sel_adr_s     & act_s;
    assign load_ACC    = load_acc_s    & act_s;
    assign sel_ual     = sel_ual_s     & act_s;
    assign load_carry  = load_carry_s  & act_s;
    assign clear_carry = clear_carry_s & act_s;
    assign mem_ce      = mem_ce_s      & act_s;
    assign mem_we      = mem_we_s      & act_s;
    assign instr_done  = done_s        & act_s;
    assign state_o     = state_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: one instance at MEM_LAT=1, one at MEM_LAT=2.
// Strobe vectors: {clear_PC,load_PC,enable_PC,load_RI,sel_adr,load_ACC,sel_ual,load_carry,clear_carry,mem_ce,mem_we,instr_done}.
module tb_cpu_ctrl_fsm;

    localparam logic [11:0] CLR  = 12'h800;
    localparam logic [11:0] LPC  = 12'h400;
    localparam logic [11:0] EPC  = 12'h200;
    localparam logic [11:0] LRI  = 12'h100;
    localparam logic [11:0] SADR = 12'h080;
    localparam logic [11:0] LACC = 12'h040;
    localparam logic [11:0] SUAL = 12'h020;
    localparam logic [11:0] LCAR = 12'h010;
    localparam logic [11:0] CCAR = 12'h008;
    localparam logic [11:0] MCE  = 12'h004;
    localparam logic [11:0] MWE  = 12'h002;
    localparam logic [11:0] DONE = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    localparam logic [11:0] S_INIT = 12'd0, S_FETCH = 12'd1, S_DECODE = 12'd2, S_OPF = 12'd3;
    localparam logic [11:0] S_EXEC = 12'd4, S_STORE = 12'd5, S_JUMP = 12'd6, S_WAIT = 12'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic [1:0]  ins_op = 2'b01;
    logic        carry = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    logic        step_i = 1'b0;
`endif
    logic [11:0] s1, s2;
    logic [3:0]  st1, st2;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst), .ce(ce),
`ifdef CPU_CTRL_STEP_EN
        .step(step_i),
`endif
        .ins_op(ins_op), .carry(carry),
        .clear_PC(s1[11]), .load_PC(s1[10]), .enable_PC(s1[9]), .load_RI(s1[8]),
        .sel_adr(s1[7]), .load_ACC(s1[6]), .sel_ual(s1[5]), .load_carry(s1[4]),
        .clear_carry(s1[3]), .mem_ce(s1[2]), .mem_we(s1[1]), .instr_done(s1[0]),
        .state_o(st1)
    );

    cpu_ctrl_fsm #(.MEM_LAT(2)) u2 (
        .clk(clk), .rst(rst), .ce(ce),
`ifdef CPU_CTRL_STEP_EN
        .step(step_i),
`endif
        .ins_op(ins_op), .carry(carry),
        .clear_PC(s2[11]), .load_PC(s2[10]), .enable_PC(s2[9]), .load_RI(s2[8]),
        .sel_adr(s2[7]), .load_ACC(s2[6]), .sel_ual(s2[5]), .load_carry(s2[4]),
        .clear_carry(s2[3]), .mem_ce(s2[2]), .mem_we(s2[1]), .instr_done(s2[0]),
        .state_o(st2)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leaves time 2 units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #1;
        chk("rst_state1", {8'd0, st1}, S_INIT);
        chk("rst_strb1", s1, NONE);
        chk("rst_strb2", s2, NONE);
        tick();
        rst = 1'b0;
        #1;
        chk("init_state1", {8'd0, st1}, S_INIT);
        chk("init_strb1", s1, CLR | EPC);
        tick(); #1;

`ifdef CPU_CTRL_STEP_EN
        chk("init_to_wait", {8'd0, st1}, S_WAIT);
        chk("wait_strb", s1, NONE);
        ins_op = 2'b10;
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        #1;
        chk("step_fetch", {8'd0, st1}, S_FETCH);
        chk("step_fetch_strb", s1, MCE);
        tick(); #1;
        chk("step_decode", {8'd0, st1}, S_DECODE);
        tick(); #1;
        chk("step_store", s1, MCE | MWE | SADR | DONE);
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            chk("hold_state", {8'd0, st1}, S_WAIT);
            chk("hold_strb", s1, NONE);
        end
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        #1;
        chk("release_fetch", {8'd0, st1}, S_FETCH);
`else
        chk("fetch_state1", {8'd0, st1}, S_FETCH);
        chk("fetch_strb1", s1, MCE);

        // ADD at MEM_LAT=2: FETCH x2, DECODE, OPFETCH x2, EXEC.
        ins_op = 2'b01;
        do_reset();
        done_cnt = 0;
        tick(); #1; chk("add_f1", {8'd0, st2}, S_FETCH); chk("add_f1_s", s2, MCE); done_cnt += int'(s2[0]);
        tick(); #1; chk("add_f2", {8'd0, st2}, S_FETCH); done_cnt += int'(s2[0]);
        tick(); #1; chk("add_dec_s", s2, LRI | EPC); done_cnt += int'(s2[0]);
        tick(); #1; chk("add_o1", {8'd0, st2}, S_OPF); chk("add_o1_s", s2, MCE | SADR); done_cnt += int'(s2[0]);
        tick(); #1; chk("add_o2", {8'd0, st2}, S_OPF); done_cnt += int'(s2[0]);
        tick(); #1; chk("add_exec", {8'd0, st2}, S_EXEC);
        chk("add_exec_s", s2, LACC | SUAL | LCAR | DONE); done_cnt += int'(s2[0]);
        chk("add_done_cnt", 12'(done_cnt), 12'd1);
        tick(); #1; chk("add_next", {8'd0, st2}, S_FETCH);

        // JCC at MEM_LAT=2, carry both ways in the JUMP cycle.
        ins_op = 2'b11;
        carry = 1'b0;
        do_reset();
        tick(); tick(); tick(); tick(); #1;
        chk("jcc_state", {8'd0, st2}, S_JUMP);
        chk("jcc_c0", s2, LPC | DONE);
        carry = 1'b1;
        #1;
        chk("jcc_c1", s2, CCAR | DONE);
        tick(); #1;
        chk("jcc_next", {8'd0, st2}, S_FETCH);
        carry = 1'b0;

        // STA at MEM_LAT=1, then async reset in the middle of a second STORE.
        ins_op = 2'b10;
        do_reset();
        tick(); #1; chk("sta_fetch", s1, MCE);
        tick(); #1; chk("sta_dec", s1, LRI | EPC);
        tick(); #1; chk("sta_state", {8'd0, st1}, S_STORE);
        chk("sta_strb", s1, MCE | MWE | SADR | DONE);
        tick(); #1; chk("sta_after", s1, MCE);
        tick(); tick(); #1;
        chk("sta2_strb", s1, MCE | MWE | SADR | DONE);
        rst = 1'b1;
        #1;
        chk("sta_rst_state", {8'd0, st1}, S_INIT);
        chk("sta_rst_strb", s1, NONE);

        // NOR at MEM_LAT=2 with ce low for 3 cycles from the first OPFETCH cycle.
        ins_op = 2'b00;
        do_reset();
        tick(); tick(); tick(); tick();
        ce = 1'b0;
        #1;
        chk("ce_opf_state", {8'd0, st2}, S_OPF);
        chk("ce_opf_strb", s2, NONE);
        tick(); #1; chk("ce_hold1", {8'd0, st2}, S_OPF); chk("ce_hold1_s", s2, NONE);
        tick(); #1; chk("ce_hold2", {8'd0, st2}, S_OPF);
        tick();
        ce = 1'b1;
        #1;
        chk("ce_resume", s2, MCE | SADR);
        tick(); #1; chk("ce_opf2", {8'd0, st2}, S_OPF);
        tick(); #1; chk("ce_exec", {8'd0, st2}, S_EXEC);
        chk("ce_exec_s", s2, LACC | DONE);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
